irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that sits directly upstream of the main decoder's exception entry. It collects asynchronous event sources (timer `flag`, debounced push-buttons), edge-detects and latches them as pending, and applies a software mask. It presents the highest-priority request to the CPU as `irq` plus a handler `vector`, and holds the CPU in service until software writes end-of-interrupt. Registers share the 5-bit peripheral address space used by the timer.

---
 rtl/irq_ctrl_pkg.sv | 28 ++
 rtl/irq_ctrl_if.sv | 22 ++
 rtl/irq_edge_sync.sv | 26 ++
 rtl/irq_ctrl.sv | 138 +++++++++++++
 tb/tb_irq_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: peripheral address map, FSM encoding
// and the handler-vector helper.
package irq_ctrl_pkg;

    // Timer registers share the 5-bit peripheral space
    localparam logic [4:0] TMR_CTRL_A  = 5'b10110;
    localparam logic [4:0] TMR_CNT_A   = 5'b10111;

    localparam logic [4:0] IRQ_MASK_A  = 5'b11000;
    localparam logic [4:0] IRQ_PEND_A  = 5'b11001;
    localparam logic [4:0] IRQ_CAUSE_A = 5'b11010;
    localparam logic [4:0] IRQ_EOI_A   = 5'b11011;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'b00,
        IRQ_REQ  = 2'b01,
        IRQ_SVC  = 2'b10
    } irq_state_t;

    function automatic logic [31:0] irq_vec(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [2:0]  id
    );
        return base + stride * {29'b0, id};
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus plus CPU request/ack bundle of the interrupt controller.
// master = CPU side, slave = controller side.
interface irq_ctrl_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
    logic        ack;
    logic [31:0] vector;
    logic        active;

    modport master (
        output we, addr, wd, ack,
        input  rd, irq, vector, active
    );

    modport slave (
        input  we, addr, wd, ack,
        output rd, irq, vector, active
    );
endinterface

// File: rtl/irq_edge_sync.sv
// Per-source 2-flop synchroniser followed by a previous-value register;
// rise pulses for one cycle on each synchronised rising edge.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, mask,
// fixed priority (source 0 highest) and a request/service/EOI handshake.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NSRC       = 4,
    parameter logic [31:0] VEC_BASE   = 32'h180,
    parameter logic [31:0] VEC_STRIDE = 32'h8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    irq_ctrl_if.slave       bus
);
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pm;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] clr;
    logic [2:0]      hid;
    logic [2:0]      active_id;
    logic            req;
    logic            take;
    logic            mask_we;
    logic            pend_we;
    logic            eoi;
    logic            irq_q;
    logic            active_q;
    irq_state_t      state;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (src[g]),
            .rise (rise[g])
        );
    end

    assign pm  = pend & mask;
    assign req = |pm;

    always_comb begin
        hid = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pm[i]) hid = 3'(i);
        end
    end

    assign mask_we = bus.we && (bus.addr == IRQ_MASK_A);
    assign pend_we = bus.we && (bus.addr == IRQ_PEND_A);
    assign eoi     = bus.we && (bus.addr == IRQ_EOI_A);
    assign take    = (state == IRQ_REQ) && bus.ack && req;
    assign w1c     = pend_we ? bus.wd[NSRC-1:0] : '0;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr[i] = take && (hid == 3'(i));
        end
    end

    // A fresh rise wins over both W1C and the ack clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            pend <= '0;
        end else begin
            if (mask_we) mask <= bus.wd[NSRC-1:0];
            pend <= (pend & ~w1c & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IRQ_IDLE;
            irq_q     <= 1'b0;
            active_q  <= 1'b0;
            active_id <= 3'd0;
        end else begin
            unique case (state)
                IRQ_IDLE: begin
                    if (req) begin
                        state <= IRQ_REQ;
                        irq_q <= 1'b1;
                    end
                end
                IRQ_REQ: begin
                    if (!req) begin
                        state <= IRQ_IDLE;
                        irq_q <= 1'b0;
                    end else if (bus.ack) begin
                        state     <= IRQ_SVC;
                        irq_q     <= 1'b0;
                        active_q  <= 1'b1;
                        active_id <= hid;
                    end
                end
                IRQ_SVC: begin
                    if (eoi) begin
                        state    <= IRQ_IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IRQ_IDLE;
                    irq_q    <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        unique case (state)
            IRQ_REQ: bus.vector = irq_vec(VEC_BASE, VEC_STRIDE, hid);
            IRQ_SVC: bus.vector = irq_vec(VEC_BASE, VEC_STRIDE, active_id);
            default: bus.vector = VEC_BASE;
        endcase
    end

    always_comb begin
        bus.rd = '0;
        unique case (1'b1)
            bus.addr == IRQ_MASK_A:  bus.rd = 32'(mask);
            bus.addr == IRQ_PEND_A:  bus.rd = 32'(pend);
            bus.addr == IRQ_CAUSE_A: bus.rd = {active_q, 28'b0, active_id};
            default:                 bus.rd = '0;
        endcase
    end

    assign bus.irq    = irq_q;
    assign bus.active = active_q;

    logic unused_wd;
    assign unused_wd = ^bus.wd[31:NSRC];
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, single source, priority, masking
// and edge/W1C/ack/EOI collisions against hand-computed values.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] src;
    int         n_chk;
    int         n_pass;

    irq_ctrl_if b ();

    irq_ctrl #(
        .NSRC       (4),
        .VEC_BASE   (32'h180),
        .VEC_STRIDE (32'h8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        b.we   = 1'b1;
        b.addr = a;
        b.wd   = d;
        tick();
        b.we   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a,
                           input logic [31:0] exp);
        b.addr = a;
        #1;
        chk(tag, b.rd, exp);
    endtask

    task automatic do_ack();
        b.ack = 1'b1;
        tick();
        b.ack = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        src    = '0;
        b.we   = 1'b0;
        b.addr = '0;
        b.wd   = '0;
        b.ack  = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();

        chk("rst_irq", 32'(b.irq), 32'd0);
        chk("rst_active", 32'(b.active), 32'd0);
        chk("rst_vector", b.vector, 32'h180);
        chk_reg("rst_mask", IRQ_MASK_A, 32'h0);
        chk_reg("rst_cause", IRQ_CAUSE_A, 32'h0);
        chk_reg("unmapped_rd", TMR_CTRL_A, 32'h0);

        // single source
        wr(IRQ_MASK_A, 32'h4);
        chk_reg("mask_rd", IRQ_MASK_A, 32'h4);
        src[2] = 1'b1;
        ticks(3);
        chk_reg("s_pend_k2", IRQ_PEND_A, 32'h4);
        chk("s_irq_k2", 32'(b.irq), 32'd0);
        tick();
        chk("s_irq_k3", 32'(b.irq), 32'd1);
        chk("s_vec", b.vector, 32'h190);
        src[2] = 1'b0;
        do_ack();
        chk("s_irq_ack", 32'(b.irq), 32'd0);
        chk("s_active_ack", 32'(b.active), 32'd1);
        chk_reg("s_cause", IRQ_CAUSE_A, 32'h8000_0002);
        chk_reg("s_pend_ack", IRQ_PEND_A, 32'h0);
        chk("s_vec_svc", b.vector, 32'h190);
        wr(IRQ_EOI_A, 32'h0);
        chk("s_active_eoi", 32'(b.active), 32'd0);
        tick();
        chk("s_irq_idle", 32'(b.irq), 32'd0);
        chk("s_vec_idle", b.vector, 32'h180);

        // priority
        wr(IRQ_MASK_A, 32'hF);
        src[3] = 1'b1;
        ticks(2);
        src[1] = 1'b1;
        ticks(2);
        chk("p_irq", 32'(b.irq), 32'd1);
        chk("p_vec3", b.vector, 32'h198);
        ticks(2);
        chk("p_vec1", b.vector, 32'h188);
        src = '0;
        do_ack();
        chk_reg("p_cause", IRQ_CAUSE_A, 32'h8000_0001);
        chk_reg("p_pend", IRQ_PEND_A, 32'h8);
        wr(IRQ_EOI_A, 32'h0);
        chk("p_active_eoi", 32'(b.active), 32'd0);
        chk("p_irq_n", 32'(b.irq), 32'd0);
        tick();
        chk("p_irq_n1", 32'(b.irq), 32'd1);
        chk("p_vec_re", b.vector, 32'h198);
        do_ack();
        wr(IRQ_EOI_A, 32'h0);

        // masking
        wr(IRQ_MASK_A, 32'h0);
        src[0] = 1'b1;
        ticks(3);
        chk_reg("m_pend", IRQ_PEND_A, 32'h1);
        tick();
        chk("m_irq_masked", 32'(b.irq), 32'd0);
        src[0] = 1'b0;
        wr(IRQ_MASK_A, 32'h1);
        tick();
        chk("m_irq_unmask", 32'(b.irq), 32'd1);
        chk("m_vec0", b.vector, 32'h180);
        wr(IRQ_MASK_A, 32'h0);
        tick();
        chk("m_irq_drop", 32'(b.irq), 32'd0);
        chk_reg("m_pend_kept", IRQ_PEND_A, 32'h1);
        wr(IRQ_MASK_A, 32'h1);
        tick();
        // ack together with a mask-clear write must still be taken
        b.ack  = 1'b1;
        b.we   = 1'b1;
        b.addr = IRQ_MASK_A;
        b.wd   = 32'h0;
        tick();
        b.ack  = 1'b0;
        b.we   = 1'b0;
        chk("m_ack_mask_act", 32'(b.active), 32'd1);
        chk_reg("m_ack_cause", IRQ_CAUSE_A, 32'h8000_0000);
        chk_reg("m_ack_pend", IRQ_PEND_A, 32'h0);
        wr(IRQ_EOI_A, 32'h0);

        // collisions
        src[1] = 1'b1;
        ticks(2);
        wr(IRQ_PEND_A, 32'h2);
        chk_reg("c_set_wins", IRQ_PEND_A, 32'h2);
        wr(IRQ_PEND_A, 32'h2);
        chk_reg("c_w1c", IRQ_PEND_A, 32'h0);
        src[1] = 1'b0;
        do_ack();
        chk("c_ack_idle_irq", 32'(b.irq), 32'd0);
        chk("c_ack_idle_act", 32'(b.active), 32'd0);
        wr(IRQ_EOI_A, 32'h0);
        chk_reg("c_eoi_idle", IRQ_CAUSE_A, 32'h0);
        src[0] = 1'b1;
        ticks(5);
        chk_reg("c_hold_set", IRQ_PEND_A, 32'h1);
        wr(IRQ_PEND_A, 32'h1);
        ticks(14);
        chk_reg("c_hold_once", IRQ_PEND_A, 32'h0);
        src[0] = 1'b0;
        ticks(3);
        src[0] = 1'b1;
        ticks(3);
        chk_reg("c_rearm", IRQ_PEND_A, 32'h1);
        src[0] = 1'b0;
        wr(IRQ_PEND_A, 32'h1);

        // reset while in service
        wr(IRQ_MASK_A, 32'h4);
        src[2] = 1'b1;
        ticks(4);
        src[2] = 1'b0;
        do_ack();
        chk("r_pre_active", 32'(b.active), 32'd1);
        src[3] = 1'b1;
        ticks(3);
        rst = 1'b1;
        #1;
        chk("r_irq", 32'(b.irq), 32'd0);
        chk("r_active", 32'(b.active), 32'd0);
        chk("r_vector", b.vector, 32'h180);
        chk_reg("r_mask", IRQ_MASK_A, 32'h0);
        chk_reg("r_pend", IRQ_PEND_A, 32'h0);
        src = '0;
        tick();
        rst = 1'b0;
        ticks(2);
        chk("r_post_irq", 32'(b.irq), 32'd0);
        chk_reg("r_post_cause", IRQ_CAUSE_A, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
